// File: rtl/seq_bit_counter_if.sv
// Handshake bundle for seq_bit_counter: word-in channel and count-out channel.
// out_lead exists only when LZC_EN is defined.
interface seq_bit_counter_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
`ifdef LZC_EN
    logic [CW-1:0]    out_lead;
`endif

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count
`ifdef LZC_EN
        , input out_lead
`endif
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count
`ifdef LZC_EN
        , output out_lead
`endif
    );
endinterface

// File: rtl/seq_bit_counter.sv
// Multi-cycle MSB-first zero/one counter, CHUNK bits per cycle; LZC_EN adds out_lead.
// Latency WIDTH/CHUNK cycles from accept to out_valid; one word in flight at a time.
// Result held while out_ready is low; in_ready only in IDLE, one idle cycle between words.
module seq_bit_counter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_bit_counter_if.slave   bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             mode_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    count_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] raw_chunk;
    logic [CHUNK-1:0] cnt_chunk;
    logic [CW-1:0]    chunk_ones;
    logic [CW-1:0]    acc_d;
    logic             last_chunk;

    always_comb begin
        raw_chunk  = shreg_q[WIDTH-1 -: CHUNK];
        cnt_chunk  = mode_q ? raw_chunk : ~raw_chunk;
        chunk_ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_ones = chunk_ones + CW'(cnt_chunk[i]);
        end
        acc_d      = acc_q + chunk_ones;
        last_chunk = (idx_q == IW'(NCH - 1));
    end

`ifdef LZC_EN
    logic          seen_q;
    logic [CW-1:0] lacc_q;
    logic [CW-1:0] lead_q;
    logic [CW-1:0] chunk_lz;
    logic          chunk_hit;
    logic [CW-1:0] lacc_d;

    // Zeros above the first '1' of this chunk; once a '1' was seen, nothing more is added.
    always_comb begin
        chunk_lz  = '0;
        chunk_hit = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (raw_chunk[i]) begin
                chunk_hit = 1'b1;
            end else if (!chunk_hit) begin
                chunk_lz = chunk_lz + CW'(1);
            end
        end
        lacc_d = seen_q ? lacc_q : (lacc_q + chunk_lz);
    end

    assign bus.out_lead = lead_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            mode_q      <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef LZC_EN
            seen_q      <= 1'b0;
            lacc_q      <= '0;
            lead_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        shreg_q    <= bus.in_data;
                        mode_q     <= bus.in_mode;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
`ifdef LZC_EN
                        seen_q     <= 1'b0;
                        lacc_q     <= '0;
`endif
                    end
                end
                BUSY: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q << CHUNK;
                    idx_q   <= idx_q + IW'(1);
`ifdef LZC_EN
                    lacc_q  <= lacc_d;
                    seen_q  <= seen_q | chunk_hit;
`endif
                    if (last_chunk) begin
                        count_q     <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef LZC_EN
                        lead_q      <= lacc_d;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_seq_bit_counter.sv
// Directed bench for seq_bit_counter (8/2) plus a random sweep of three 32-bit builds.
module tb_seq_bit_counter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_bit_counter_if #(.WIDTH(8),  .CW(4)) bus8 ();
    seq_bit_counter_if #(.WIDTH(32), .CW(6)) b1 ();
    seq_bit_counter_if #(.WIDTH(32), .CW(6)) b4 ();
    seq_bit_counter_if #(.WIDTH(32), .CW(6)) b32 ();

    seq_bit_counter #(.WIDTH(8),  .CHUNK(2))  u8   (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    seq_bit_counter #(.WIDTH(32), .CHUNK(1))  u1   (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    seq_bit_counter #(.WIDTH(32), .CHUNK(4))  u4   (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    seq_bit_counter #(.WIDTH(32), .CHUNK(32)) u32  (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

    logic        sw_valid;
    logic [31:0] sw_data;
    logic        sw_mode;
    logic        sw_ready;

    assign b1.in_valid  = sw_valid;
    assign b1.in_data   = sw_data;
    assign b1.in_mode   = sw_mode;
    assign b1.out_ready = sw_ready;
    assign b4.in_valid  = sw_valid;
    assign b4.in_data   = sw_data;
    assign b4.in_mode   = sw_mode;
    assign b4.out_ready = sw_ready;
    assign b32.in_valid  = sw_valid;
    assign b32.in_data   = sw_data;
    assign b32.in_mode   = sw_mode;
    assign b32.out_ready = sw_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic m);
        int w;
        w = 0;
        while (bus8.in_ready !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("send_ready", bus8.in_ready, 1);
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        bus8.in_mode  = m;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.in_data  = ~d;
        bus8.in_mode  = ~m;
    endtask

    task automatic wait8(input string tag);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid === 1'b1) lat = c;
        end
        check({tag, "_lat"}, lat, 4);
    endtask

    task automatic run8(input string tag, input logic [7:0] d, input logic m,
                        input int exp_cnt, input int exp_lead);
        send8(d, m);
        wait8(tag);
        check({tag, "_cnt"}, bus8.out_count, exp_cnt);
`ifdef LZC_EN
        check({tag, "_lead"}, bus8.out_lead, exp_lead);
`else
        if (exp_lead < 0) $display("note: negative lead for %s", tag);
`endif
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check({tag, "_drop"}, bus8.out_valid, 0);
        check({tag, "_idle"}, bus8.in_ready, 1);
    endtask

    function automatic int lead32(input logic [31:0] d);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) hit = 1'b1;
            else if (!hit) n++;
        end
        return n;
    endfunction

    initial begin
        int l1, l4, l32, ones, exp_cnt;
        bit seen_valid;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_mode   = 1'b0;
        bus8.out_ready = 1'b0;
        sw_valid = 1'b0;
        sw_data  = '0;
        sw_mode  = 1'b0;
        sw_ready = 1'b0;

        // Reset asserted between edges takes effect at once.
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  bus8.in_ready, 1);
        check("rst_out_valid", bus8.out_valid, 0);
        check("rst_out_count", bus8.out_count, 0);
`ifdef LZC_EN
        check("rst_out_lead",  bus8.out_lead, 0);
`endif
        #18 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("rst_no_result", seen_valid, 0);

        run8("w2D_m0", 8'b0010_1101, 1'b0, 4, 2);
        run8("w2D_m1", 8'b0010_1101, 1'b1, 4, 2);
        run8("w00_m0", 8'h00, 1'b0, 8, 8);
        run8("w00_m1", 8'h00, 1'b1, 0, 8);
        run8("wFF_m1", 8'hFF, 1'b1, 8, 0);
        run8("wFF_m0", 8'hFF, 1'b0, 0, 0);
        run8("w01_m0", 8'h01, 1'b0, 7, 7);

        // Backpressure: result holds, competing input word is ignored.
        send8(8'hB7, 1'b1);
        wait8("bp");
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h00;
        bus8.in_mode  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", bus8.out_valid, 1);
            check("bp_count", bus8.out_count, 6);
            check("bp_in_ready", bus8.in_ready, 0);
            @(posedge clk); #1;
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("bp_release_valid", bus8.out_valid, 0);
        check("bp_release_ready", bus8.in_ready, 1);
        check("bp_retain_count", bus8.out_count, 6);
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("bp_ignored_word", seen_valid, 0);

        // Reset after two chunks of a scan.
        send8(8'h5A, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midbusy_valid", bus8.out_valid, 0);
        check("midbusy_ready", bus8.in_ready, 1);
        check("midbusy_count", bus8.out_count, 0);
        #2 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("midbusy_no_result", seen_valid, 0);
        run8("wF0_m1", 8'hF0, 1'b1, 4, 0);

        // Reset while a result waits for out_ready.
        send8(8'h3C, 1'b0);
        wait8("middone");
        #2 rst_n = 1'b0;
        #1;
        check("middone_valid", bus8.out_valid, 0);
        check("middone_count", bus8.out_count, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run8("w80_m0", 8'h80, 1'b0, 7, 0);

        // Random sweep across three CHUNK builds of a 32-bit counter.
        for (int n = 0; n < 1000; n++) begin
            sw_data  = $urandom;
            sw_mode  = 1'($urandom_range(0, 1));
            sw_valid = 1'b1;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            l1 = 0; l4 = 0; l32 = 0;
            for (int c = 1; c <= 40 && (l1 == 0 || l4 == 0 || l32 == 0); c++) begin
                @(posedge clk); #1;
                if (b1.out_valid  === 1'b1 && l1  == 0) l1  = c;
                if (b4.out_valid  === 1'b1 && l4  == 0) l4  = c;
                if (b32.out_valid === 1'b1 && l32 == 0) l32 = c;
            end
            ones = $countones(sw_data);
            exp_cnt = sw_mode ? ones : 32 - ones;
            check("sw_c1_lat",  l1,  32);
            check("sw_c4_lat",  l4,  8);
            check("sw_c32_lat", l32, 1);
            check("sw_c1_cnt",  b1.out_count,  exp_cnt);
            check("sw_c4_cnt",  b4.out_count,  exp_cnt);
            check("sw_c32_cnt", b32.out_count, exp_cnt);
`ifdef LZC_EN
            check("sw_c1_lead",  b1.out_lead,  lead32(sw_data));
            check("sw_c4_lead",  b4.out_lead,  lead32(sw_data));
            check("sw_c32_lead", b32.out_lead, lead32(sw_data));
`else
            if (lead32(sw_data) > 32) $display("note: lead model out of range");
`endif
            sw_ready = 1'b1;
            @(posedge clk); #1;
            sw_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
